serial_pattern_generator: RTL and testbench
===========================================

Name: serial_pattern_generator

Overview:
Serial bit-pattern transmitter, the stimulus/driver side of the serial sequence detectors.
- Captures a parallel pattern, length and repeat count on a start request.
- Shifts the pattern out MSB-first, one bit per clock, on a single serial line, back-to-back for the requested number of repetitions.
- Signals busy/valid/done for the consuming logic.
- Feeds detector `x` inputs in system test and BIST paths.

Parameters:
- PAT_W, 8, maximum pattern width in bits (≥2).
- LEN_W, 4, width of `len` input; must satisfy 2^LEN_W > PAT_W.
- REP_W, 4, width of `reps` input.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, transmit request; sampled only in IDLE.
- pattern, input, PAT_W, bits to send; the active bits are `pattern[len-1:0]`.
- len, input, LEN_W, number of pattern bits per repetition.
- reps, input, REP_W, number of repetitions.
- x, output, 1, serial data bit (registered).
- valid, output, 1, high in every cycle where `x` carries a pattern bit.
- busy, output, 1, high from the first cycle after accepted start through the done cycle.
- done, output, 1, one-cycle completion pulse.

Behaviour:
- Reset:
  - Synchronous active-high: on any clk edge with rst=1, state=IDLE and x=valid=busy=done=0.
  - Internal shift register and counters cleared.
  - Reset overrides start and aborts a transfer in progress; no done pulse is produced.
- All outputs are registered (Moore): no combinational path from inputs to outputs.
- States and transitions:
  - IDLE: outputs 0.
    - start=1 at edge t → capture pattern, effective length L and effective repeat count R.
    - If L=0 → DONE; else → SHIFT.
  - SHIFT: valid=1, busy=1, x=current bit.
    - The bit index decrements from L-1 to 0.
    - At index 0 with repetitions remaining → reload index L-1, decrement repetition counter, stay in SHIFT. There is no idle gap between repetitions.
    - At index 0 of the last repetition → DONE.
  - DONE: valid=0, x=0, busy=1, done=1 for exactly one cycle → IDLE.
- Width rules:
  - L = len clamped to PAT_W (len>PAT_W sends PAT_W bits).
  - R = reps, except reps=0 is treated as 1.
  - Only the captured copy of `pattern` is used; changes on `pattern`/`len`/`reps` after capture have no effect.
- Latency:
  - Start accepted at edge t → first bit on x (valid=1) during cycle t+1.
  - Total valid cycles = L*R.
  - done asserts in cycle t+1+L*R.
  - For L=0: done in cycle t+1, valid never asserts.
- Ordering: MSB first within each repetition, i.e. `pattern[L-1]`, …, `pattern[0]`.
- Handshake:
  - start while busy=1 (SHIFT or DONE) is ignored, not queued.
  - start held high continuously → new transfer accepted in the IDLE cycle after done, then repeats.
- rst and start asserted on the same edge → reset wins; state stays IDLE.
- `x` is 0 whenever valid=0.

Test Plan:
1. PAT_W=8, pattern=8'b0000_0111, len=3, reps=1, start pulse at t → valid=1 and x=1,1,1 in cycles t+1..t+3; done=1 at t+4; busy high t+1..t+4. When x drives a 111 detector, the detector flags the run.
2. pattern=8'b0000_1011, len=4, reps=3 → x stream 1011 1011 1011 over 12 consecutive valid cycles with no gaps; done at t+13.
3. len=0, reps=5 → valid never asserts; busy and done high only in cycle t+1; back to IDLE at t+2.
4. len=12 (PAT_W=8), pattern=8'hA5, reps=0 → 8 bits 10100101 (clamped length, reps treated as 1); done at t+9. A second start pulse at t+4 produces no effect and no extra bits.
5. Reset mid-transfer: start with len=8, assert rst on the edge ending cycle t+3 → from the next cycle x=valid=busy=done=0, no done pulse. A new start afterwards transmits the full new pattern from its MSB.
6. start held high with pattern changing each cycle → each transfer uses the pattern captured at its own accept edge; successive transfers are separated by exactly one DONE cycle plus one IDLE cycle.

Source files
------------

// File: rtl/serial_pattern_generator.sv
// ---------------------------------------------------------------------------
// serial_pattern_generator
//
// Serial bit-pattern transmitter. A start request in IDLE captures a parallel
// pattern, a length and a repeat count. The active bits pattern[L-1:0] are then
// shifted out MSB-first, one bit per clock, back-to-back for R repetitions.
// A one-cycle done pulse follows the last bit.
//
// Ports:
//   i_clk     - rising-edge clock
//   i_rst     - synchronous active-high reset; aborts any transfer, no done
//   i_start   - transmit request, sampled only while idle
//   i_pattern - bits to send; the active bits are i_pattern[len-1:0]
//   i_len     - bits per repetition; values above PAT_W are clamped to PAT_W
//   i_reps    - repetition count; 0 is treated as 1
//   o_x       - serial data bit; forced to 0 whenever o_valid is low
//   o_valid   - high in every cycle where o_x carries a pattern bit
//   o_busy    - high from the first cycle after an accepted start through done
//   o_done    - one-cycle completion pulse
//
// Every output is a flop. The next-state logic also computes the next output
// values, so there is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module serial_pattern_generator #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic [LEN_W-1:0] i_len,
  input  logic [REP_W-1:0] i_reps,
  output logic             o_x,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_done
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
  localparam logic [REP_W-1:0] REP_ZERO = {REP_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_idx;
  // Repetitions still to send after the current one.
  logic [REP_W-1:0] r_rep;
  logic             r_x;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [PAT_W-1:0] w_pat_nxt;
  logic [LEN_W-1:0] w_len_nxt;
  logic [LEN_W-1:0] w_idx_nxt;
  logic [REP_W-1:0] w_rep_nxt;
  logic [LEN_W-1:0] w_len_eff;
  logic [REP_W-1:0] w_rep_eff;
  logic             w_x_nxt;
  logic             w_valid_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  // Effective length and repeat count of a request.
  always_comb begin
    w_len_eff = (i_len > LEN_MAX) ? LEN_MAX : i_len;
    w_rep_eff = (i_reps == REP_ZERO) ? REP_ONE : i_reps;
  end

  // Next-state and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    w_rep_nxt   = r_rep;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_pat_nxt = i_pattern;
          w_len_nxt = w_len_eff;
          w_rep_nxt = w_rep_eff - REP_ONE;
          if (w_len_eff == LEN_ZERO) begin
            w_state_nxt = ST_DONE;
            w_idx_nxt   = LEN_ZERO;
          end else begin
            w_state_nxt = ST_SHIFT;
            w_idx_nxt   = w_len_eff - LEN_ONE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_idx == LEN_ZERO) begin
          if (r_rep != REP_ZERO) begin
            // Wrap to the MSB of the next repetition with no idle gap.
            w_idx_nxt = r_len - LEN_ONE;
            w_rep_nxt = r_rep - REP_ONE;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_idx_nxt = r_idx - LEN_ONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output values for the next cycle, decoded from the next state.
  always_comb begin
    w_valid_nxt = (w_state_nxt == ST_SHIFT);
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
    w_done_nxt  = (w_state_nxt == ST_DONE);
    if (w_valid_nxt) begin
      w_x_nxt = w_pat_nxt[w_idx_nxt[IDX_W-1:0]];
    end else begin
      w_x_nxt = 1'b0;
    end
  end

  // State, capture registers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_pat   <= {PAT_W{1'b0}};
      r_len   <= LEN_ZERO;
      r_idx   <= LEN_ZERO;
      r_rep   <= REP_ZERO;
      r_x     <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pat   <= w_pat_nxt;
      r_len   <= w_len_nxt;
      r_idx   <= w_idx_nxt;
      r_rep   <= w_rep_nxt;
      r_x     <= w_x_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_x     = r_x;
  assign o_valid = r_valid;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: tb/tb_serial_pattern_generator.sv
// ---------------------------------------------------------------------------
// Testbench for serial_pattern_generator (PAT_W=8, LEN_W=4, REP_W=4).
// A reference model turns every accepted request into a queue of expected
// per-cycle outputs {x, valid, busy, done}. The queue holds L*R data cycles
// followed by one done cycle. A request is accepted only when the current
// expected cycle is not busy.
// ---------------------------------------------------------------------------
module tb_serial_pattern_generator;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] reps;
  logic       x;
  logic       valid;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected outputs of the current cycle and of the cycles still to come.
  logic [3:0] cur = 4'b0000;
  logic [3:0] q[$];

  serial_pattern_generator #(
    .PAT_W(8),
    .LEN_W(4),
    .REP_W(4)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_pattern(pattern),
    .i_len    (len),
    .i_reps   (reps),
    .o_x      (x),
    .o_valid  (valid),
    .o_busy   (busy),
    .o_done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour at one rising edge, using the inputs present at it.
  task automatic model_edge();
    int l_eff;
    int r_eff;
    if (rst) begin
      q.delete();
      cur = 4'b0000;
    end else begin
      if (!cur[1] && start) begin
        l_eff = (int'(len) > 8) ? 8 : int'(len);
        r_eff = (reps == 4'd0) ? 1 : int'(reps);
        for (int r = 0; r < r_eff; r++) begin
          for (int b = l_eff - 1; b >= 0; b--) begin
            q.push_back({pattern[b], 1'b1, 1'b1, 1'b0});
          end
        end
        q.push_back(4'b0011);
      end
      if (q.size() > 0) cur = q.pop_front();
      else cur = 4'b0000;
    end
  endtask

  // One clock cycle: drive inputs, advance through the edge, compare outputs.
  task automatic cyc(input logic s, input logic [7:0] p, input logic [3:0] l,
                     input logic [3:0] r, input logic rs);
    start   = s;
    pattern = p;
    len     = l;
    reps    = r;
    rst     = rs;
    @(posedge clk);
    model_edge();
    #1;
    check("x",     x,     cur[3]);
    check("valid", valid, cur[2]);
    check("busy",  busy,  cur[1]);
    check("done",  done,  cur[0]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom), 4'($urandom), 4'($urandom), 1'b0);
  endtask

  initial begin
    start   = 1'b0;
    pattern = 8'h00;
    len     = 4'd0;
    reps    = 4'd0;
    rst     = 1'b1;

    // Reset, including reset winning over a simultaneous start.
    cyc(1'b0, 8'h00, 4'd0, 4'd0, 1'b1);
    cyc(1'b1, 8'hFF, 4'd8, 4'd2, 1'b1);
    idle(2);

    // 111 once.
    cyc(1'b1, 8'b0000_0111, 4'd3, 4'd1, 1'b0);
    idle(5);

    // 1011 three times, back-to-back.
    cyc(1'b1, 8'b0000_1011, 4'd4, 4'd3, 1'b0);
    idle(14);

    // Zero length: done only, no valid.
    cyc(1'b1, 8'hFF, 4'd0, 4'd5, 1'b0);
    idle(3);

    // Clamped length, reps=0, second start at t+4 ignored.
    cyc(1'b1, 8'hA5, 4'd12, 4'd0, 1'b0);
    idle(3);
    cyc(1'b1, 8'h3C, 4'd5, 4'd2, 1'b0);
    idle(8);

    // Reset on the edge ending cycle t+3, then a fresh transfer.
    cyc(1'b1, 8'h96, 4'd8, 4'd1, 1'b0);
    idle(2);
    cyc(1'b0, 8'h00, 4'd0, 4'd0, 1'b1);
    idle(3);
    cyc(1'b1, 8'hC3, 4'd8, 4'd2, 1'b0);
    idle(20);

    // start held high, pattern changing every cycle.
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 8'($urandom), 4'($urandom_range(12, 1)), 4'($urandom_range(2, 0)), 1'b0);
    end
    idle(12);

    // Randomized requests with occasional resets.
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom_range(3, 0) == 0), 8'($urandom), 4'($urandom_range(15, 0)),
          4'($urandom_range(4, 0)), ($urandom_range(60, 0) == 0));
    end
    idle(80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
